// File: rtl/hilo_div.sv
// Iterative radix-2 restoring divider producing {HI, LO} = {remainder, quotient}.
// Handles DIV/DIVU, divide-by-zero and pipeline-flush cancel.
module hilo_div #(
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic        cancel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        ready,
    output logic [63:0] result
);
    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dsr_q, dsr_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        zero_q, zero_d;
    logic [63:0] result_q, result_d;

    logic [31:0] a_mag, b_mag;
    logic [32:0] partial, diff;
    logic        fits;
    logic [31:0] rem_step, quot_step;
    logic [31:0] rem_fix, quot_fix;

    always_comb begin
        a_mag     = (signed_div && a[31]) ? (~a + 32'd1) : a;
        b_mag     = (signed_div && b[31]) ? (~b + 32'd1) : b;
        // Dividend bits shift out of quot_q's MSB while quotient bits shift in at the LSB.
        partial   = {rem_q, quot_q[31]};
        diff      = partial - {1'b0, dsr_q};
        fits      = (partial >= {1'b0, dsr_q});
        rem_step  = fits ? diff[31:0] : partial[31:0];
        quot_step = {quot_q[30:0], fits};
        rem_fix   = rneg_q ? (~rem_step + 32'd1) : rem_step;
        quot_fix  = qneg_q ? (~quot_step + 32'd1) : quot_step;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        zero_d   = zero_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dvd_d  = a;
                    dsr_d  = b_mag;
                    quot_d = a_mag;
                    rem_d  = 32'd0;
                    qneg_d = signed_div & (a[31] ^ b[31]);
                    rneg_d = signed_div & a[31];
                    zero_d = (b == 32'd0);
                    cnt_d  = 6'd0;
                    if (EARLY_ZERO && (b == 32'd0)) begin
                        state_d  = StDone;
                        result_d = {a, 32'hFFFF_FFFF};
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d  = rem_step;
                quot_d = quot_step;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d  = StDone;
                    result_d = zero_q ? {dvd_q, 32'hFFFF_FFFF} : {rem_fix, quot_fix};
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Flush wins over everything, including a same-cycle start; result is preserved.
        if (cancel) begin
            state_d  = StIdle;
            cnt_d    = 6'd0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= 6'd0;
            dvd_q    <= 32'd0;
            dsr_q    <= 32'd0;
            quot_q   <= 32'd0;
            rem_q    <= 32'd0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            zero_q   <= zero_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == StCalc);
    assign ready  = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_hilo_div.sv
// Self-checking bench for hilo_div: vector table plus hand-written cancel/reset/ignore sequences,
// with a result scoreboard queue pushed at start and popped on ready.
module tb_hilo_div;
    logic        clk = 1'b0;
    logic        rst, start, start_nz, signed_div, cancel;
    logic [31:0] a, b;
    logic        busy, ready, busy_nz, ready_nz;
    logic [63:0] result, result_nz;

    int tests = 0;
    int failed = 0;
    logic [63:0] sb[$];
    logic [63:0] last_res = 64'd0;

    always #5 clk = ~clk;

    hilo_div #(.EARLY_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .cancel(cancel),
        .a(a), .b(b), .busy(busy), .ready(ready), .result(result)
    );

    hilo_div #(.EARLY_ZERO(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .start(start_nz), .signed_div(signed_div), .cancel(cancel),
        .a(a), .b(b), .busy(busy_nz), .ready(ready_nz), .result(result_nz)
    );

    typedef struct {
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Entered at the negedge of cycle 'first' (start already dropped); cycle 0 was the start.
    task automatic wait_ready(input bit nz, input int first, input int exp_lat, input string name);
        int          lat;
        int          busy_cnt;
        bit          got;
        logic [63:0] exp;
        lat = first;
        busy_cnt = 0;
        got = 1'b0;
        while (!got && lat <= 40) begin
            if (nz ? ready_nz : ready) begin
                got = 1'b1;
            end else begin
                if (nz ? busy_nz : busy) busy_cnt++;
                lat++;
                @(negedge clk);
            end
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat - first));
        exp = (sb.size() != 0) ? sb.pop_front() : 64'hx;
        if (got) begin
            check({name, " busy at ready"}, 64'(nz ? busy_nz : busy), 64'd0);
            check({name, " result"}, nz ? result_nz : result, exp);
            @(negedge clk);
            check({name, " ready pulse"}, 64'(nz ? ready_nz : ready), 64'd0);
            check({name, " result hold"}, nz ? result_nz : result, exp);
            if (!nz) last_res = exp;
        end
    endtask

    task automatic run_op(input bit nz, input logic sd, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] exp, input int lat, input string name);
        @(negedge clk);
        a = av;
        b = bv;
        signed_div = sd;
        if (nz) start_nz = 1'b1;
        else start = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        start_nz = 1'b0;
        wait_ready(nz, 1, lat, name);
    endtask

    initial begin
        int rdy_seen;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                   33, "divu 100/7"};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},    33, "div -7/2"};
        vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},            33, "div min/-1"};
        vecs[3] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'd0},            33, "divu big/max"};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF},            33, "divu max/1"};
        vecs[5] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},            33, "div 7/-2"};
        vecs[6] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'd14},           33, "div -100/-7"};
        vecs[7] = '{1'b0, 32'h0000_1234,  32'd0,          {32'h0000_1234, 32'hFFFF_FFFF},    1,  "divu by zero"};
        vecs[8] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          {32'hFFFF_FFF9, 32'hFFFF_FFFF},    1,  "div by zero"};

        rst = 1'b0;
        start = 1'b1;
        start_nz = 1'b1;
        signed_div = 1'b0;
        cancel = 1'b0;
        a = 32'd100;
        b = 32'd7;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset ready", 64'(ready), 64'd0);
        check("reset result", result, 64'd0);
        check("reset nz busy", 64'(busy_nz), 64'd0);
        check("reset nz result", result_nz, 64'd0);
        rst = 1'b1;
        start = 1'b0;
        start_nz = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(1'b0, vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);
        end

        run_op(1'b1, 1'b0, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 33, "div0 full iteration");

        // Start pulsed mid-CALC with different operands must be ignored.
        @(negedge clk);
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        sb.push_back({32'd2, 32'd14});
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a = 32'd50; b = 32'd3; signed_div = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ready(1'b0, 6, 33, "start during calc");

        // Cancel in cycle 10, restart in cycle 11.
        @(negedge clk);
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rdy_seen = 0;
        for (int c = 1; c < 10; c++) begin
            if (ready) rdy_seen++;
            @(negedge clk);
        end
        check("busy before cancel", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel busy", 64'(busy), 64'd0);
        check("cancel ready", 64'(ready), 64'd0);
        check("cancel result kept", result, last_res);
        check("cancel no early ready", 64'(rdy_seen), 64'd0);
        a = 32'd9; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        sb.push_back({32'd0, 32'd3});
        @(negedge clk);
        start = 1'b0;
        wait_ready(1'b0, 1, 33, "restart after cancel");

        // Cancel beats a same-cycle start.
        @(negedge clk);
        a = 32'd5; b = 32'd1; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("cancel vs start busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("cancel vs start ready", 64'(ready), 64'd0);

        // Reset in cycle 20 of an operation.
        @(negedge clk);
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset ready", 64'(ready), 64'd0);
        check("mid reset result", result, 64'd0);
        rst = 1'b1;
        rdy_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (ready || busy) rdy_seen++;
        end
        check("no activity after reset", 64'(rdy_seen), 64'd0);

        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "post reset div");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/hilo_div.md
HILO_DIV -- requirements
Module: hilo_div

Interface
REQ-001 SHALL have parameter: EARLY_ZERO, default 1, meaning a divide-by-zero completes in one cycle instead of the full iteration.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have port: start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port: signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; captured with start.
REQ-006 SHALL have port: cancel  input  1  pipeline flush; aborts any operation.
REQ-007 SHALL have port: a  input  32  dividend; captured with start.
REQ-008 SHALL have port: b  input  32  divisor; captured with start.
REQ-009 SHALL have port: busy  output  1  high while iterating; drives the pipeline stall.
REQ-010 SHALL have port: ready  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port: result  output  64  {remainder, quotient}, i.e. {HI, LO}, for the HILO write port.

Function
REQ-012 SHALL implement states IDLE, CALC, DONE with a 6-bit iteration counter.
REQ-013 SHALL, in IDLE with start=1 and cancel=0, capture a, b, signed_div and go to CALC (or DONE per REQ-019).
REQ-014 SHALL ignore start in CALC and DONE; operands are not re-sampled.
REQ-015 SHALL perform one restoring shift-subtract step on operand magnitudes per CALC cycle, for exactly 32 cycles, then go to DONE.
REQ-016 SHALL time each operation: start high in cycle 0; busy=1 in cycles 1..32; ready=1, busy=0 in cycle 33; IDLE in cycle 34, where a new start is accepted.
REQ-017 SHALL, when signed_div=1, negate the quotient iff sign(a) != sign(b) and give the remainder the sign of a; the result is {rem, quot}.
REQ-018 SHALL give 0x80000000 / 0xFFFFFFFF (signed) quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-019 SHALL, when b==0: with EARLY_ZERO=1 go IDLE->DONE directly (ready in cycle 1, busy never set); with EARLY_ZERO=0 run the full 32 cycles. Either way result = {a, 32'hFFFFFFFF}, independent of signed_div.
REQ-020 SHALL hold result stable from DONE until the next accepted start; ready is high for exactly one cycle.
REQ-021 SHALL, on cancel=1 in any state, go to IDLE at the next edge; busy=0 and ready=0 in the following cycle; result unchanged; cancel has priority over start in the same cycle.
REQ-022 SHALL accept a start in the cycle directly after a cancel.

Reset
REQ-023 SHALL, while rst=0 at a rising edge, enter IDLE with counter=0, busy=0, ready=0, result=64'h0 and internal operand registers cleared.
REQ-024 SHALL abandon an operation in progress on reset mid-CALC or DONE, with no ready pulse.
REQ-025 SHALL ignore start while rst=0.

Verification
REQ-026 SHALL verify: unsigned a=100, b=7, start -> busy cycles 1..32, ready in cycle 33, result={32'd2, 32'd14}.
REQ-027 SHALL verify: signed a=-7 (0xFFFFFFF9), b=2 -> result={32'hFFFFFFFF, 32'hFFFFFFFD}; and a=0x80000000, b=0xFFFFFFFF -> result={0, 32'h80000000}.
REQ-028 SHALL verify: b=0, a=0x1234, EARLY_ZERO=1 -> ready in cycle 1, result={32'h1234, 32'hFFFFFFFF}; EARLY_ZERO=0 -> ready in cycle 33 with the same result.
REQ-029 SHALL verify: cancel in cycle 10 -> busy=0 from cycle 11, no ready; a new start (9/3, unsigned) in cycle 11 -> result={0, 3} in cycle 44.
REQ-030 SHALL verify: start pulsed during CALC with other operands -> ignored; the original result is returned unchanged.
REQ-031 SHALL verify: rst=0 in cycle 20 of an operation -> all outputs 0 next cycle, no ready pulse; start with rst=0 -> no effect.
